// File: rtl/des_pkg.sv
// DES constants and bit-exact permutation / S-box helpers shared by the CFB decryptor.
// DES bit n (1 = MSB) of a W-bit vector sits at index W-n.
package des_pkg;

  typedef enum logic {ST_IDLE = 1'b0, ST_ROUND = 1'b1} state_t;

  localparam logic [4:0] FIN_RND = 5'd17;

  localparam int IP_T [64] = '{58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
                               62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
                               57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
                               61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int FP_T [64] = '{40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
                               38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
                               36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
                               34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};
  localparam int E_T [48] = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13,
                              12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21, 22, 23,
                              24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
  localparam int P_T [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                              2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
  localparam int PC1_T [56] = '{57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
                                10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
                                63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
                                14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
  localparam int PC2_T [48] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
                                23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
                                41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                                44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SHIFT_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Entry (row*16 + col) occupies nibble [255-4*idx -: 4].
  localparam logic [255:0] SBOX_T [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  function automatic logic [63:0] perm_ip(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
    return y;
  endfunction

  function automatic logic [63:0] perm_fp(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
    return y;
  endfunction

  function automatic logic [47:0] perm_e(input logic [31:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[47-i] = x[32-E_T[i]];
    return y;
  endfunction

  function automatic logic [31:0] perm_p(input logic [31:0] x);
    logic [31:0] y;
    for (int i = 0; i < 32; i++) y[31-i] = x[32-P_T[i]];
    return y;
  endfunction

  function automatic logic [55:0] perm_pc1(input logic [63:0] x);
    logic [55:0] y;
    for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
    return y;
  endfunction

  function automatic logic [47:0] perm_pc2(input logic [55:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
    return y;
  endfunction

  // Outer bits b1,b6 pick the row, inner bits b2..b5 the column.
  function automatic logic [3:0] sbox_lu(input int n, input logic [5:0] b);
    int idx;
    idx = int'({b[5], b[0], b[4:1]});
    return SBOX_T[n][255-4*idx -: 4];
  endfunction

endpackage

// File: rtl/des_round.sv
// One DES Feistel round: f-function on R with the round subkey, then L/R swap.
module des_round
  import des_pkg::*;
(
  input  logic [31:0] i_l,
  input  logic [31:0] i_r,
  input  logic [47:0] i_k,
  output logic [31:0] o_l,
  output logic [31:0] o_r
);

  logic [47:0] w_x;
  logic [31:0] w_s;

  always_comb begin
    w_x = perm_e(i_r) ^ i_k;
    w_s = '0;
    for (int s = 0; s < 8; s++) w_s[31-4*s -: 4] = sbox_lu(s, w_x[47-6*s -: 6]);
  end

  assign o_l = i_r;
  assign o_r = i_l ^ perm_p(w_s);

endmodule

// File: rtl/cfb_dec.sv
// CFB-64 DES block decryptor: plain = cipher XOR DES_enc(key, iv), one round per clock.
// Start at edge 0, rounds on edges 1..16, result and valid pulse at edge 17.
module cfb_dec
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [64:1] cipher_in,
  input  logic [64:1] key,
  input  logic [64:1] iv,
  output logic [64:1] plain_out,
  output logic        valid_out,
  output logic        busy
);

  state_t      r_state;
  logic [4:0]  r_round;
  logic [27:0] r_c, r_d;
  logic [31:0] r_l, r_r;
  logic [63:0] r_cipher;

  logic [3:0]  w_sidx;
  logic [27:0] w_c, w_d;
  logic [47:0] w_k;
  logic [31:0] w_l_nx, w_r_nx;
  logic [55:0] w_cd0;
  logic [63:0] w_lr0;

  // Round 16 has r_round=16, whose low nibble wraps to schedule index 15.
  assign w_sidx = r_round[3:0] - 4'd1;

  always_comb begin
    if (SHIFT_T[w_sidx] == 1) begin
      w_c = {r_c[26:0], r_c[27]};
      w_d = {r_d[26:0], r_d[27]};
    end else begin
      w_c = {r_c[25:0], r_c[27:26]};
      w_d = {r_d[25:0], r_d[27:26]};
    end
  end

  assign w_k   = perm_pc2({w_c, w_d});
  assign w_cd0 = perm_pc1(key);
  assign w_lr0 = perm_ip(iv);

  des_round u_round (
    .i_l (r_l),
    .i_r (r_r),
    .i_k (w_k),
    .o_l (w_l_nx),
    .o_r (w_r_nx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_round   <= '0;
      r_c       <= '0;
      r_d       <= '0;
      r_l       <= '0;
      r_r       <= '0;
      r_cipher  <= '0;
      plain_out <= '0;
      valid_out <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_cipher <= cipher_in;
            r_c      <= w_cd0[55:28];
            r_d      <= w_cd0[27:0];
            r_l      <= w_lr0[63:32];
            r_r      <= w_lr0[31:0];
            r_round  <= 5'd1;
            busy     <= 1'b1;
            r_state  <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          if (r_round == FIN_RND) begin
            plain_out <= r_cipher ^ perm_fp({r_r, r_l});
            valid_out <= 1'b1;
            busy      <= 1'b0;
            r_round   <= '0;
            r_state   <= ST_IDLE;
          end else begin
            r_c     <= w_c;
            r_d     <= w_d;
            r_l     <= w_l_nx;
            r_r     <= w_r_nx;
            r_round <= r_round + 5'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cfb_dec.sv
// Self-checking bench for cfb_dec: whole-block DES reference plus a cycle-level
// protocol model compared every cycle, and literal known-answer vectors.
module tb_cfb_dec;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [64:1] cipher_in = '0;
  logic [64:1] key = '0;
  logic [64:1] iv = '0;
  logic [64:1] plain_out;
  logic        valid_out;
  logic        busy;

  always #5 clk = ~clk;

  cfb_dec dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cipher_in (cipher_in),
    .key       (key),
    .iv        (iv),
    .plain_out (plain_out),
    .valid_out (valid_out),
    .busy      (busy)
  );

  int n_err = 0;
  int n_chk = 0;
  bit chk_en = 1'b0;

  localparam int IP_B [64] = '{58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
                               62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
                               57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
                               61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int FP_B [64] = '{40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
                               38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
                               36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
                               34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};
  localparam int E_B [48] = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13,
                              12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21, 22, 23,
                              24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
  localparam int P_B [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                              2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
  localparam int PC1_B [56] = '{57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
                                10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
                                63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
                                14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
  localparam int PC2_B [48] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
                                23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
                                41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                                44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SHIFT_B [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Row (4*box + row) of the eight S-boxes, 16 columns each.
  localparam int SB_B [32][16] = '{
    '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7},
    '{0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8},
    '{4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0},
    '{15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
    '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10},
    '{3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5},
    '{0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15},
    '{13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
    '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8},
    '{13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1},
    '{13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7},
    '{1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
    '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15},
    '{13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9},
    '{10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4},
    '{3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
    '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9},
    '{14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6},
    '{4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14},
    '{11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
    '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11},
    '{10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8},
    '{9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6},
    '{4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
    '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1},
    '{13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6},
    '{1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2},
    '{6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
    '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7},
    '{1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2},
    '{7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8},
    '{2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

  // Whole-block DES encryption: full subkey list first, then 16 Feistel rounds.
  function automatic logic [63:0] des_enc(input logic [63:0] k, input logic [63:0] blk);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] sub [16];
    logic [63:0] t, y;
    logic [31:0] l, r, nl, pf, sv;
    logic [47:0] x;
    logic [5:0]  six;
    int row, col;
    for (int i = 0; i < 56; i++) cd[55-i] = k[64-PC1_B[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int n = 0; n < 16; n++) begin
      for (int j = 0; j < SHIFT_B[n]; j++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) sub[n][47-i] = cd[56-PC2_B[i]];
    end
    for (int i = 0; i < 64; i++) t[63-i] = blk[64-IP_B[i]];
    l = t[63:32];
    r = t[31:0];
    for (int n = 0; n < 16; n++) begin
      for (int i = 0; i < 48; i++) x[47-i] = r[32-E_B[i]];
      x = x ^ sub[n];
      for (int b = 0; b < 8; b++) begin
        six = x[47-6*b -: 6];
        row = (six[5] ? 2 : 0) + (six[0] ? 1 : 0);
        col = int'(six[4:1]);
        sv[31-4*b -: 4] = 4'(SB_B[4*b+row][col]);
      end
      for (int i = 0; i < 32; i++) pf[31-i] = sv[32-P_B[i]];
      nl = r;
      r  = l ^ pf;
      l  = nl;
    end
    t = {r, l};
    for (int i = 0; i < 64; i++) y[63-i] = t[64-FP_B[i]];
    return y;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Protocol model: accepts start when idle, result due 17 edges later.
  logic        m_busy = 1'b0;
  logic        m_valid = 1'b0;
  logic [63:0] m_plain = '0;
  logic [63:0] m_pend = '0;
  int          m_cnt = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_plain <= '0;
      m_cnt   <= 0;
    end else begin
      m_valid <= 1'b0;
      if (!m_busy && start) begin
        m_busy <= 1'b1;
        m_cnt  <= 17;
        m_pend <= cipher_in ^ des_enc(key, iv);
      end else if (m_busy) begin
        if (m_cnt == 1) begin
          m_busy  <= 1'b0;
          m_valid <= 1'b1;
          m_plain <= m_pend;
        end
        m_cnt <= m_cnt - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_valid", {63'd0, valid_out}, {63'd0, m_valid});
      chk("cyc_busy", {63'd0, busy}, {63'd0, m_busy});
      chk("cyc_plain", plain_out, m_plain);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issues one block and waits (bounded) for its valid pulse; lat = edges after start edge.
  task automatic run_block(input logic [63:0] c, input logic [63:0] k, input logic [63:0] v,
                           output int lat);
    cipher_in = c;
    key       = k;
    iv        = v;
    start     = 1'b1;
    tick(1);
    start = 1'b0;
    lat   = -1;
    for (int n = 1; n <= 40; n++) begin
      tick(1);
      if (valid_out) begin
        lat = n;
        break;
      end
    end
  endtask

  localparam logic [63:0] K1  = 64'h133457799BBCDFF1;
  localparam logic [63:0] IV1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] KS1 = 64'h85E813540F0AB405;
  localparam logic [63:0] K2  = 64'h0E329232EA6D0D73;
  localparam logic [63:0] IV2 = 64'h8787878787878787;

  logic [63:0] chain_c [4] = '{64'hDEADBEEFCAFEF00D, 64'h0011223344556677,
                               64'h8899AABBCCDDEEFF, 64'hFEDCBA9876543210};

  initial begin
    int lat;
    int pulses;
    logic [63:0] prev;

    chk("model_canon", des_enc(K1, IV1), KS1);
    chk("model_key2", des_enc(K2, IV2), 64'h0);

    rst = 1'b1;
    tick(2);
    chk("rst_plain", plain_out, 64'h0);
    chk("rst_valid", {63'd0, valid_out}, 64'h0);
    chk("rst_busy", {63'd0, busy}, 64'h0);
    chk_en = 1'b1;
    rst = 1'b0;
    tick(2);

    run_block(64'h0, K1, IV1, lat);
    chk("canon_lat", 64'(lat), 64'd17);
    chk("canon_plain", plain_out, KS1);
    tick(1);
    chk("canon_pulse_len", {63'd0, valid_out}, 64'h0);
    chk("canon_hold", plain_out, KS1);

    run_block(KS1, K1, IV1, lat);
    chk("zero_lat", 64'(lat), 64'd17);
    chk("zero_plain", plain_out, 64'h0);

    run_block(64'hFFFFFFFFFFFFFFFF, K2, IV2, lat);
    chk("key2_lat", 64'(lat), 64'd17);
    chk("key2_plain", plain_out, 64'hFFFFFFFFFFFFFFFF);

    // Second start mid-block plus input changes must not disturb the block in flight.
    cipher_in = 64'h0;
    key       = K1;
    iv        = IV1;
    start     = 1'b1;
    tick(1);
    start = 1'b0;
    tick(4);
    cipher_in = 64'hFFFFFFFFFFFFFFFF;
    iv        = 64'h1111111111111111;
    key       = K2;
    start     = 1'b1;
    tick(1);
    start     = 1'b0;
    cipher_in = 64'h5555AAAA5555AAAA;
    iv        = 64'h2222222222222222;
    lat = -1;
    for (int n = 6; n <= 40; n++) begin
      tick(1);
      if (valid_out) begin
        lat = n;
        break;
      end
    end
    chk("busy_rej_lat", 64'(lat), 64'd17);
    chk("busy_rej_plain", plain_out, KS1);
    pulses = 0;
    for (int n = 0; n < 25; n++) begin
      tick(1);
      if (valid_out) pulses++;
    end
    chk("busy_rej_extra", 64'(pulses), 64'd0);
    chk("busy_rej_idle", {63'd0, busy}, 64'h0);

    // Back-to-back CFB chain: each block's iv is the previous ciphertext.
    prev = K1;
    for (int i = 0; i < 4; i++) begin
      run_block(chain_c[i], K1, prev, lat);
      chk("chain_lat", 64'(lat), 64'd17);
      chk("chain_plain", plain_out, chain_c[i] ^ des_enc(K1, prev));
      prev = chain_c[i];
    end
    tick(2);

    // Abort mid-block: reset around round 8, no result may appear.
    cipher_in = 64'h0;
    key       = K1;
    iv        = IV1;
    start     = 1'b1;
    tick(1);
    start = 1'b0;
    tick(7);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    pulses = 0;
    for (int n = 0; n < 30; n++) begin
      tick(1);
      if (valid_out) pulses++;
    end
    chk("abort_pulses", 64'(pulses), 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'h0);
    chk("abort_plain", plain_out, 64'h0);

    run_block(64'h0, K1, IV1, lat);
    chk("recover_lat", 64'(lat), 64'd17);
    chk("recover_plain", plain_out, KS1);
    tick(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
    $fatal(1);
  end

endmodule
